// File: rtl/icache_axi_refill.sv
// icache_axi_refill: AXI4 INCR read-burst master that refills one instruction-cache line per request.
// Latency: accept->arvalid_o 1 cycle, rlast handshake->rvalid_o 1 cycle (NBEAT+2 total with zero-wait AXI).
// Backpressure: AR held stable until arready_i; rready_o high through the R phase; one burst outstanding.
// Optional feature macro ICACHE_AXI_RRESP_CHECK_EN: non-OKAY rresp_i sets err_o, sticky until rst_n.
module icache_axi_refill #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned CACHELINE_WIDTH = 128,
   parameter int unsigned AXI_DATA_WIDTH  = 32,
   parameter logic [3:0]  AXI_ID          = 4'd0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [ADDR_WIDTH-1:0]      addr_i,
   input  logic                       rreq_i,
   output logic                       rdy_o,
   output logic                       rvalid_o,
   output logic                       rlast_o,
   output logic [CACHELINE_WIDTH-1:0] data_o,
   output logic                       err_o,
   output logic [3:0]                 arid_o,
   output logic [ADDR_WIDTH-1:0]      araddr_o,
   output logic [7:0]                 arlen_o,
   output logic [2:0]                 arsize_o,
   output logic [1:0]                 arburst_o,
   output logic                       arvalid_o,
   input  logic                       arready_i,
   input  logic [3:0]                 rid_i,
   input  logic [AXI_DATA_WIDTH-1:0]  rdata_i,
   input  logic [1:0]                 rresp_i,
   input  logic                       rlast_i,
   input  logic                       rvalid_i,
   output logic                       rready_o
);

   localparam int unsigned NBEAT     = CACHELINE_WIDTH / AXI_DATA_WIDTH;
   localparam int unsigned OFFS_BITS = $clog2(CACHELINE_WIDTH / 8);
   localparam int unsigned CNT_W     = (NBEAT > 1) ? $clog2(NBEAT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NBEAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_e;

   state_e                     state_q, state_d;
   logic [ADDR_WIDTH-1:0]      araddr_q, araddr_d;
   logic [CACHELINE_WIDTH-1:0] line_q, line_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   // Set once the last slice has been written so surplus beats cannot overwrite it.
   logic                       full_q, full_d;
   // Marks the single DONE entry cycle that carries the completion pulse.
   logic                       done_q, done_d;

   logic same_line;
   logic accept;

   assign same_line = (addr_i[ADDR_WIDTH-1:OFFS_BITS] == araddr_q[ADDR_WIDTH-1:OFFS_BITS]);

   // A request is taken in IDLE, or in DONE when it names a line other than the one just delivered,
   // so a cache holding its request while the hit becomes visible does not cause a duplicate refill.
   assign accept = rreq_i && ((state_q == S_IDLE) || ((state_q == S_DONE) && !same_line));

   // Next-state, address latch, beat assembly and completion pulse.
   always_comb begin
      state_d  = state_q;
      araddr_d = araddr_q;
      line_d   = line_q;
      cnt_d    = cnt_q;
      full_d   = full_q;
      done_d   = 1'b0;
      if (accept) begin
         state_d  = S_AR;
         araddr_d = {addr_i[ADDR_WIDTH-1:OFFS_BITS], {OFFS_BITS{1'b0}}};
         line_d   = '0;
         cnt_d    = '0;
         full_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_AR: begin
               if (arready_i) begin
                  state_d = S_R;
               end
            end
            S_R: begin
               if (rvalid_i) begin
                  if (!full_q) begin
                     for (int b = 0; b < NBEAT; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                           line_d[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = rdata_i;
                        end
                     end
                     if (cnt_q == CNT_MAX) begin
                        full_d = 1'b1;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
                  if (rlast_i) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (!rreq_i) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers; reset aborts any burst without a completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         araddr_q <= '0;
         line_q   <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         araddr_q <= araddr_d;
         line_q   <= line_d;
         cnt_q    <= cnt_d;
         full_q   <= full_d;
         done_q   <= done_d;
      end
   end

`ifdef ICACHE_AXI_RRESP_CHECK_EN
   logic err_q, err_d;
   logic r_hs;
   logic unused_ok;

   assign r_hs      = (state_q == S_R) && rvalid_i;
   assign err_d     = err_q | (r_hs && (rresp_i != 2'b00));
   assign err_o     = err_q;
   assign unused_ok = ^{rid_i, addr_i[OFFS_BITS-1:0]};

   // Sticky bus-error flag; the line still completes normally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   logic unused_ok;

   assign err_o     = 1'b0;
   assign unused_ok = ^{rid_i, rresp_i, addr_i[OFFS_BITS-1:0]};
`endif

   assign rdy_o     = (state_q == S_IDLE) || ((state_q == S_DONE) && !(rreq_i && same_line));
   assign rvalid_o  = done_q;
   assign rlast_o   = done_q;
   assign data_o    = line_q;
   assign araddr_o  = araddr_q;
   assign arvalid_o = (state_q == S_AR);
   assign rready_o  = (state_q == S_R);
   assign arid_o    = AXI_ID;
   assign arlen_o   = 8'(NBEAT - 1);
   assign arsize_o  = 3'($clog2(AXI_DATA_WIDTH / 8));
   assign arburst_o = 2'b01;

endmodule

// File: tb/tb_icache_axi_refill.sv
// tb_icache_axi_refill: directed refills against icache_axi_refill with a queue-based scoreboard.
// Expected lines and AR addresses are queued by the stimulus; monitors pop them on rvalid_o / AR handshake.
// Covers reset, zero-wait and throttled bursts, held requests, back-to-back lines, short/long bursts, errors.
module tb_icache_axi_refill;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  addr_i;
   logic         rreq_i;
   logic         rdy_o;
   logic         rvalid_o;
   logic         rlast_o;
   logic [127:0] data_o;
   logic         err_o;
   logic [3:0]   arid_o;
   logic [31:0]  araddr_o;
   logic [7:0]   arlen_o;
   logic [2:0]   arsize_o;
   logic [1:0]   arburst_o;
   logic         arvalid_o;
   logic         arready_i;
   logic [3:0]   rid_i;
   logic [31:0]  rdata_i;
   logic [1:0]   rresp_i;
   logic         rlast_i;
   logic         rvalid_i;
   logic         rready_o;

`ifdef ICACHE_AXI_RRESP_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   always #5 clk = ~clk;

   icache_axi_refill dut (
      .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .rreq_i(rreq_i), .rdy_o(rdy_o),
      .rvalid_o(rvalid_o), .rlast_o(rlast_o), .data_o(data_o), .err_o(err_o),
      .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
      .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
      .rvalid_i(rvalid_i), .rready_o(rready_o)
   );

   int checks   = 0;
   int errors   = 0;
   int rv_count = 0;
   int ar_count = 0;
   logic [127:0] exp_line_q[$];
   logic [31:0]  exp_addr_q[$];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chka(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Line monitor: every completion pulse must match the oldest queued line.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rvalid_o === 1'b1) begin
         rv_count++;
         chki("line_expected", int'(exp_line_q.size() > 0), 1);
         if (exp_line_q.size() > 0) begin
            chkw("line_data", data_o, exp_line_q.pop_front());
            chk1("line_rlast", rlast_o, 1'b1);
         end
      end
   end

   // AR monitor: every address handshake must match the oldest queued address and burst shape.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && arvalid_o === 1'b1 && arready_i === 1'b1) begin
         ar_count++;
         chki("ar_expected", int'(exp_addr_q.size() > 0), 1);
         if (exp_addr_q.size() > 0) begin
            chka("araddr", araddr_o, exp_addr_q.pop_front());
            chka("arlen", 32'(arlen_o), 32'd3);
            chka("arsize", 32'(arsize_o), 32'd2);
            chka("arburst", 32'(arburst_o), 32'd1);
            chka("arid", 32'(arid_o), 32'd0);
         end
      end
   end

   // Issues one request and plays the slave side; returns in the cycle rvalid_o is expected.
   task automatic refill(input logic [31:0] addr, input logic [191:0] words, input int nbeats,
                         input logic [127:0] exp_line, input int ar_wait, input int gap,
                         input int bad_beat);
      int          waits;
      logic [31:0] exp_a;
      exp_a = addr & 32'hFFFF_FFF0;
      exp_addr_q.push_back(exp_a);
      exp_line_q.push_back(exp_line);
      addr_i = addr;
      rreq_i = 1'b1;
      waits  = 0;
      do begin
         @(posedge clk); #1;
         waits++;
      end while (arvalid_o !== 1'b1 && waits < 20);
      chki("accept_to_arvalid", waits, 1);
      chk1("ar_phase_rdy", rdy_o, 1'b0);
      repeat (ar_wait) begin
         @(posedge clk); #1;
         chk1("ar_hold_valid", arvalid_o, 1'b1);
         chka("ar_hold_addr", araddr_o, exp_a);
      end
      arready_i = 1'b1;
      @(posedge clk); #1;
      arready_i = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         rvalid_i = 1'b0;
         rlast_i  = 1'b0;
         repeat (gap) begin
            @(posedge clk); #1;
         end
         rvalid_i = 1'b1;
         rdata_i  = words[b*32 +: 32];
         rlast_i  = (b == nbeats - 1);
         rresp_i  = (b == bad_beat) ? 2'b10 : 2'b00;
         chk1("r_phase_rready", rready_o, 1'b1);
         @(posedge clk); #1;
         if (b == bad_beat) chk1("err_rise", err_o, EXP_ERR);
      end
      rvalid_i = 1'b0;
      rlast_i  = 1'b0;
      rresp_i  = 2'b00;
      chk1("rvalid_latency", rvalid_o, 1'b1);
   endtask

   task automatic go_idle();
      rreq_i = 1'b0;
      @(posedge clk); #1;
      chk1("idle_rdy", rdy_o, 1'b1);
      chk1("rvalid_one_cycle", rvalid_o, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int rv0;
      int ar0;
      rst_n = 1'b0; addr_i = '0; rreq_i = 1'b0; arready_i = 1'b0; rid_i = 4'h5;
      rdata_i = '0; rresp_i = 2'b00; rlast_i = 1'b0; rvalid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_rdy", rdy_o, 1'b1);
      chk1("rst_rvalid", rvalid_o, 1'b0);
      chk1("rst_rlast", rlast_o, 1'b0);
      chk1("rst_arvalid", arvalid_o, 1'b0);
      chk1("rst_rready", rready_o, 1'b0);
      chk1("rst_err", err_o, 1'b0);
      chkw("rst_data", data_o, 128'h0);
      chka("rst_araddr", araddr_o, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic zero-wait refill; the line then holds while idle.
      refill(32'h1C001234, {64'h0, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4,
             128'h44444444_33333333_22222222_11111111, 0, 0, -1);
      go_idle();
      chkw("data_hold_idle", data_o, 128'h44444444_33333333_22222222_11111111);

      // AR stalled 5 cycles and 2-cycle gaps between beats.
      ar0 = ar_count;
      refill(32'h2000005C, {64'h0, 32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1}, 4,
             128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1, 5, 2, -1);
      go_idle();
      chki("bp_single_ar", ar_count - ar0, 1);

      // Request held on the same line for 10 cycles after completion.
      rv0 = rv_count;
      ar0 = ar_count;
      refill(32'h1C001230, {64'h0, 32'hFEEDFACE, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF}, 4,
             128'hFEEDFACE_89ABCDEF_01234567_DEADBEEF, 0, 0, -1);
      repeat (10) begin
         @(posedge clk); #1;
         chk1("held_no_arvalid", arvalid_o, 1'b0);
         chk1("held_rdy_low", rdy_o, 1'b0);
      end
      chki("held_one_rvalid", rv_count - rv0, 1);
      chki("held_one_ar", ar_count - ar0, 1);

      // Switch to another line while still in DONE, then again from the DONE entry cycle.
      refill(32'h1C001240, {64'h0, 32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000}, 4,
             128'h5A5A0003_5A5A0002_5A5A0001_5A5A0000, 0, 0, -1);
      refill(32'h00000FFC, {128'h0, 32'hCAFE0001, 32'hCAFE0000}, 2,
             128'h00000000_00000000_CAFE0001_CAFE0000, 0, 0, -1);
      go_idle();
      chki("b2b_lines", rv_count - rv0, 3);

      // Six beats with rlast on the last: beats past the fourth are dropped.
      refill(32'hFFFFFFFF, {32'h00000066, 32'h00000055, 32'h00000044, 32'h00000033, 32'h00000022,
             32'h00000011}, 6, 128'h00000044_00000033_00000022_00000011, 1, 1, -1);
      go_idle();

      // Reset after two beats aborts the line.
      exp_addr_q.push_back(32'h12345670);
      addr_i = 32'h12345678;
      rreq_i = 1'b1;
      @(posedge clk); #1;
      chk1("abort_arvalid", arvalid_o, 1'b1);
      arready_i = 1'b1;
      @(posedge clk); #1;
      arready_i = 1'b0;
      rvalid_i = 1'b1; rdata_i = 32'hBAD00000;
      @(posedge clk); #1;
      rdata_i = 32'hBAD00001;
      @(posedge clk); #1;
      rvalid_i = 1'b0;
      rreq_i   = 1'b0;
      rv0      = rv_count;
      #2 rst_n = 1'b0;
      #1;
      chk1("abort_rdy", rdy_o, 1'b1);
      chk1("abort_rready", rready_o, 1'b0);
      chk1("abort_arvalid_low", arvalid_o, 1'b0);
      chk1("abort_rvalid", rvalid_o, 1'b0);
      chkw("abort_data", data_o, 128'h0);
      chka("abort_araddr", araddr_o, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      refill(32'h12345678, {64'h0, 32'h13579BDF, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h76543210}, 4,
             128'h13579BDF_F0F0F0F0_0F0F0F0F_76543210, 0, 0, -1);
      go_idle();
      chki("abort_no_stale_line", rv_count - rv0, 1);

      // SLVERR on beat 1, then an OKAY refill: the flag (when built in) stays set.
      chk1("err_clear_before", err_o, 1'b0);
      refill(32'h40000008, {64'h0, 32'hE0000004, 32'hE0000003, 32'hE0000002, 32'hE0000001}, 4,
             128'hE0000004_E0000003_E0000002_E0000001, 0, 0, 1);
      chk1("err_after_line", err_o, EXP_ERR);
      go_idle();
      refill(32'h40000010, {64'h0, 32'h000000F4, 32'h000000F3, 32'h000000F2, 32'h000000F1}, 4,
             128'h000000F4_000000F3_000000F2_000000F1, 0, 0, -1);
      go_idle();
      chk1("err_sticky", err_o, EXP_ERR);

      repeat (3) @(posedge clk);
      #1;
      chki("lines_all_delivered", exp_line_q.size(), 0);
      chki("ars_all_seen", exp_addr_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
